// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter feeding the register file's single write port: the ALU has priority,
// slow results queue in a small FIFO with a starvation guard, and busy flags cover buffered rds.
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [4:0]      chk_addr1,
    input  logic [4:0]      chk_addr2,
    output logic            chk_busy1,
    output logic            chk_busy2,
    output logic            write_enable,
    output logic [4:0]      write_addr,
    output logic [XLEN-1:0] write_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    // Handshake rule for both sources: a result transfers on a cycle where valid && ready;
    // the producer must hold rd/data stable while valid && !ready.

    logic [4:0]      fifo_rd_q   [DEPTH];
    logic [4:0]      fifo_rd_d   [DEPTH];
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [XLEN-1:0] fifo_data_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ST_W-1:0]  starve_q, starve_d;
    logic             write_enable_q, write_enable_d;
    logic [4:0]       write_addr_q, write_addr_d;
    logic [XLEN-1:0]  write_data_q, write_data_d;

    logic fifo_nonempty;
    logic fifo_full;
    logic force_fifo;
    logic alu_win;
    logic pop;
    logic push;

    logic [PTR_W-1:0] entry_ofs [DEPTH];
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] hit1;
    logic [DEPTH-1:0] hit2;

    assign fifo_nonempty = (count_q != '0);
    assign fifo_full     = (count_q == CNT_W'(DEPTH));
    assign force_fifo    = fifo_nonempty && (starve_q == ST_W'(STARVE_MAX));
    assign alu_ready     = !force_fifo;
    assign lsu_ready     = !fifo_full;
    assign alu_win       = alu_valid && alu_ready;
    assign pop           = !alu_win && fifo_nonempty;
    assign push          = lsu_valid && lsu_ready && (lsu_rd != 5'd0);

    // An entry is live when its distance from the read pointer is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign entry_ofs[i]   = PTR_W'(i) - rd_ptr_q;
        assign entry_valid[i] = ({1'b0, entry_ofs[i]} < count_q);
        assign hit1[i]        = entry_valid[i] && (fifo_rd_q[i] == chk_addr1);
        assign hit2[i]        = entry_valid[i] && (fifo_rd_q[i] == chk_addr2);
    end

    assign chk_busy1 = (chk_addr1 != 5'd0) && (|hit1);
    assign chk_busy2 = (chk_addr2 != 5'd0) && (|hit2);

    assign write_enable = write_enable_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        starve_d    = starve_q;

        if (push) begin
            fifo_rd_d[wr_ptr_q]   = lsu_rd;
            fifo_data_d[wr_ptr_q] = lsu_data;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // ALU wins with an x0 destination still count against the waiting FIFO.
        if (!fifo_nonempty || pop) begin
            starve_d = '0;
        end else if (alu_win && (starve_q != ST_W'(STARVE_MAX))) begin
            starve_d = starve_q + ST_W'(1);
        end
    end

    always_comb begin
        write_enable_d = 1'b0;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        if (alu_win) begin
            if (alu_rd != 5'd0) begin
                write_enable_d = 1'b1;
                write_addr_d   = alu_rd;
                write_data_d   = alu_data;
            end
        end else if (fifo_nonempty) begin
            write_enable_d = 1'b1;
            write_addr_d   = fifo_rd_q[rd_ptr_q];
            write_data_d   = fifo_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            starve_q       <= '0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
        end else begin
            fifo_rd_q      <= fifo_rd_d;
            fifo_data_q    <= fifo_data_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            starve_q       <= starve_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic, checked against a
// queue-based reference model; expected write-backs go through a scoreboard queue.
module tb_regfile_wb_arbiter;
    localparam int XLEN       = 32;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;
    localparam int EW         = 5 + XLEN;

    logic            clk;
    logic            rst_n;
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic [4:0]      chk_addr1;
    logic [4:0]      chk_addr2;
    logic            chk_busy1;
    logic            chk_busy2;
    logic            write_enable;
    logic [4:0]      write_addr;
    logic [XLEN-1:0] write_data;

    regfile_wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // scoreboard: expected write-backs {rd, data} in retirement order
    logic [EW-1:0] exp_q[$];
    // reference model: pending slow results and consecutive losses to the ALU
    logic [EW-1:0] mq[$];
    int            starve = 0;
    logic          alu_stall = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every write the DUT presents must be the next expected one
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && write_enable) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected: got addr %0d data %0h expected no write at %0t",
                             write_addr, write_data, $time);
                end else begin
                    check("wb", {write_addr, write_data}, exp_q.pop_front());
                end
            end
        end
    end

    // driver + model: called just after a falling edge, returns at the next falling edge
    task automatic step(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [XLEN-1:0] ld,
                        input logic [4:0] c1, input logic [4:0] c2);
        int   sz;
        logic frc;
        logic b1;
        logic b2;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        lsu_valid = lv;
        lsu_rd    = lrd;
        lsu_data  = ld;
        chk_addr1 = c1;
        chk_addr2 = c2;
        #1;
        sz  = mq.size();
        frc = (sz != 0) && (starve == STARVE_MAX);
        b1  = 1'b0;
        b2  = 1'b0;
        foreach (mq[i]) begin
            if (c1 != 5'd0 && mq[i][EW-1:XLEN] == c1) b1 = 1'b1;
            if (c2 != 5'd0 && mq[i][EW-1:XLEN] == c2) b2 = 1'b1;
        end
        check("alu_ready", alu_ready, !frc);
        check("lsu_ready", lsu_ready, sz < DEPTH);
        check("chk_busy1", chk_busy1, b1);
        check("chk_busy2", chk_busy2, b2);
        if (av && !frc) begin
            if (ard != 5'd0) exp_q.push_back({ard, ad});
            if (sz != 0 && starve < STARVE_MAX) starve++;
        end else if (sz != 0) begin
            exp_q.push_back(mq.pop_front());
            starve = 0;
        end
        if (sz == 0) starve = 0;
        if (lv && sz < DEPTH && lrd != 5'd0) mq.push_back({lrd, ld});
        alu_stall = av && frc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
    endtask

    // asynchronous reset asserted between edges, released a cycle later on a falling edge
    task automatic reset_mid();
        #2;
        rst_n     = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        #1;
        check("rst_we", write_enable, 1'b0);
        check("rst_lsu_ready", lsu_ready, 1'b1);
        check("rst_alu_ready", alu_ready, 1'b1);
        exp_q.delete();
        mq.delete();
        starve    = 0;
        alu_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic            pav;
    logic [4:0]      prd;
    logic [XLEN-1:0] pad;
    int              alu_pct [3] = '{80, 95, 20};
    int              lsu_pct [3] = '{30, 90, 60};

    initial begin
        rst_n     = 1'b0;
        alu_valid = 1'b0;
        alu_rd    = '0;
        alu_data  = '0;
        lsu_valid = 1'b0;
        lsu_rd    = '0;
        lsu_data  = '0;
        chk_addr1 = 5'd1;
        chk_addr2 = 5'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_we", write_enable, 1'b0);
        check("reset_addr", write_addr, 5'd0);
        check("reset_data", write_data, '0);
        check("reset_lsu_ready", lsu_ready, 1'b1);
        check("reset_alu_ready", alu_ready, 1'b1);
        check("reset_busy1", chk_busy1, 1'b0);
        rst_n = 1'b1;

        // ALU only
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0, 5'd5, 5'd0);
        check("alu_only_we", write_enable, 1'b1);
        check("alu_only_addr", write_addr, 5'd5);
        check("alu_only_data", write_data, 32'hDEADBEEF);
        idle(2);

        // fill with ALU busy, then starvation forces rd1..rd4 out in order; full push refused then taken
        for (int k = 1; k <= 4; k++)
            step(1'b1, 5'(10 + k), 32'(k), 1'b1, 5'(k), 32'(k * 'h11), 5'd3, 5'd4);
        check("fill_lsu_ready", lsu_ready, 1'b0);
        check("fill_busy_rd3", chk_busy1, 1'b1);
        check("fill_force", alu_ready, 1'b0);
        step(1'b1, 5'd20, 32'hA0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd1);
        check("full_push_taken_next", lsu_ready, 1'b1);
        step(1'b1, 5'd20, 32'hA0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd1);
        step(1'b1, 5'd21, 32'hA1, 1'b0, 5'd0, '0, 5'd9, 5'd2);
        idle(8);

        // x0 from both sources is accepted and dropped
        step(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2, 5'd0, 5'd0);
        check("x0_busy", chk_busy1, 1'b0);
        check("x0_lsu_ready", lsu_ready, 1'b1);
        idle(2);

        // reset with three entries buffered
        for (int k = 1; k <= 3; k++)
            step(1'b1, 5'(20 + k), 32'(k), 1'b1, 5'(k), 32'(k * 'h11), 5'd1, 5'd2);
        reset_mid();
        for (int k = 1; k <= 3; k++) begin
            chk_addr1 = 5'(k);
            #1;
            check("post_reset_busy", chk_busy1, 1'b0);
        end

        // randomized traffic in phases of differing load, with one reset mid-stream
        for (int ph = 0; ph < 3; ph++) begin
            for (int n = 0; n < 600; n++) begin
                if (!alu_stall) begin
                    pav = ($urandom_range(0, 99) < alu_pct[ph]);
                    prd = 5'($urandom_range(0, 7));
                    pad = $urandom;
                end
                step(pav, prd, pad,
                     ($urandom_range(0, 99) < lsu_pct[ph]), 5'($urandom_range(0, 7)), $urandom,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
                if (ph == 1 && n == 300) reset_mid();
            end
        end

        idle(DEPTH + 4);
        check("drain_exp_q", exp_q.size(), 0);
        check("drain_model", mq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
